// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: opcodes, FSM states and the ALU pass-through code shared by the alu_seq slice.
package alu_seq_pkg;
  localparam logic [3:0] OP_ADC = 4'd0;
  localparam logic [3:0] OP_SBB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_NOT = 4'd5;
  localparam logic [3:0] OP_LD  = 4'd6;
  localparam logic [3:0] OP_ST  = 4'd8;
  localparam logic [3:0] OP_LDI = 4'd9;
  localparam logic [3:0] OP_CLC = 4'd10;
  localparam logic [3:0] OP_SEC = 4'd11;
  localparam logic [2:0] ALU_PASS = 3'b110;
  typedef enum logic {IDLE, EXEC} state_t;
endpackage

// File: rtl/alu_seq_regfile.sv
// alu_seq_regfile: NREGS x 8 register file, one sync write port, two combinational reads, async clear.
module alu_seq_regfile #(
  parameter int NREGS = 4,
  parameter int IDX_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [7:0]       wr_data,
  input  logic [IDX_W-1:0] rd_idx_a,
  output logic [7:0]       rd_data_a,
  input  logic [IDX_W-1:0] rd_idx_b,
  output logic [7:0]       rd_data_b
);
  logic [7:0] regs [NREGS];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    else if (we && int'(wr_idx) < NREGS)
      regs[wr_idx] <= wr_data;
  // out-of-range indices read as zero
  assign rd_data_a = int'(rd_idx_a) < NREGS ? regs[rd_idx_a] : '0;
  assign rd_data_b = int'(rd_idx_b) < NREGS ? regs[rd_idx_b] : '0;
endmodule

// File: rtl/alu_seq.sv
// alu_seq: two-state command sequencer driving an external 8-bit ALU with accumulator and carry writeback.
// Optional zero flag output enabled by defining ALU_SEQ_ZFLAG_EN.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int NREGS = 4,
  parameter int IDX_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_op,
  input  logic [IDX_W-1:0] cmd_idx,
  input  logic [7:0]       cmd_imm,
  output logic             done,
  output logic [7:0]       acc,
  output logic             carry,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [7:0]       rd_data,
  output logic [2:0]       alu_op,
  output logic             alu_ci,
  output logic [7:0]       alu_a,
  output logic [7:0]       alu_r,
  input  logic [7:0]       alu_result,
  input  logic             alu_co
`ifdef ALU_SEQ_ZFLAG_EN
  ,output logic            zero
`endif
);
  state_t           state;
  logic [3:0]       op_q;
  logic [IDX_W-1:0] idx_q;
  logic [7:0]       imm_q;
  logic             we;
  logic [7:0]       wdata;
  logic             arith;
  always_comb begin
    arith     = op_q == OP_ADC || op_q == OP_SBB;
    cmd_ready = state == IDLE;
    alu_a     = acc;
    alu_op    = (state == EXEC && !op_q[3]) ? op_q[2:0] : ALU_PASS;
    alu_ci    = (state == EXEC && arith) ? carry : 1'b0;
    we        = state == EXEC && (op_q == OP_ST || op_q == OP_LDI);
    wdata     = op_q == OP_LDI ? imm_q : acc;
  end
  alu_seq_regfile #(.NREGS(NREGS), .IDX_W(IDX_W)) u_rf (
    .clk      (clk),
    .rst_n    (rst_n),
    .we       (we),
    .wr_idx   (idx_q),
    .wr_data  (wdata),
    .rd_idx_a (idx_q),
    .rd_data_a(alu_r),
    .rd_idx_b (rd_idx),
    .rd_data_b(rd_data)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      op_q  <= '0;
      idx_q <= '0;
      imm_q <= '0;
      acc   <= '0;
      carry <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (cmd_valid) begin
          op_q  <= cmd_op;
          idx_q <= cmd_idx;
          imm_q <= cmd_imm;
          state <= EXEC;
        end
      end else begin
        state <= IDLE;
        done  <= 1'b1;
        if (!op_q[3]) acc <= alu_result;
        carry <= arith ? alu_co : (op_q == OP_CLC) ? 1'b0 : (op_q == OP_SEC) ? 1'b1 : carry;
      end
    end
`ifdef ALU_SEQ_ZFLAG_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) zero <= 1'b0;
    else if (state == EXEC && !op_q[3]) zero <= alu_result == 8'd0;
`endif
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed bench for alu_seq with an emulated external ALU and a spec-level reference model.
module tb_alu_seq;
  localparam int NREGS = 4;
  localparam int IDX_W = 2;
  logic clk = 0, rst_n = 0;
  logic cmd_valid = 0, cmd_ready, done, carry, alu_ci, alu_co;
  logic [3:0] cmd_op = 0;
  logic [IDX_W-1:0] cmd_idx = 0, rd_idx = 0;
  logic [7:0] cmd_imm = 0, acc, rd_data, alu_a, alu_r, alu_result;
  logic [2:0] alu_op;
  logic [8:0] alu_s;
`ifdef ALU_SEQ_ZFLAG_EN
  logic zero;
`endif
  int n_vec = 0, n_bad = 0;

  always #5 clk = ~clk;

  alu_seq #(.NREGS(NREGS), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_idx(cmd_idx), .cmd_imm(cmd_imm), .done(done),
    .acc(acc), .carry(carry), .rd_idx(rd_idx), .rd_data(rd_data),
    .alu_op(alu_op), .alu_ci(alu_ci), .alu_a(alu_a), .alu_r(alu_r),
    .alu_result(alu_result), .alu_co(alu_co)
`ifdef ALU_SEQ_ZFLAG_EN
    ,.zero(zero)
`endif
  );

  // external ALU: SBB reports borrow on carry-out
  always_comb begin
    alu_s = '0;
    alu_co = 1'b0;
    case (alu_op)
      3'd0: begin alu_s = {1'b0, alu_a} + {1'b0, alu_r} + 9'(alu_ci); alu_co = alu_s[8]; end
      3'd1: begin alu_s = {1'b0, alu_a} - {1'b0, alu_r} - 9'(alu_ci); alu_co = alu_s[8]; end
      3'd2: alu_s = {1'b0, alu_a & alu_r};
      3'd3: alu_s = {1'b0, alu_a | alu_r};
      3'd4: alu_s = {1'b0, alu_a ^ alu_r};
      3'd5: alu_s = {1'b0, ~alu_a};
      default: alu_s = {1'b0, alu_r};
    endcase
    alu_result = alu_s[7:0];
  end

  // reference model: architectural state plus one pending command
  logic [7:0] m_r [NREGS];
  logic [7:0] m_a, p_imm;
  logic m_c, m_z, busy, e_done;
  logic [3:0] p_op;
  logic [IDX_W-1:0] p_idx;

  function automatic logic [7:0] m_rd(input logic [IDX_W-1:0] i);
    return int'(i) < NREGS ? m_r[i] : 8'h00;
  endfunction

  task automatic apply();
    int v;
    logic [7:0] r;
    v = 0;
    r = m_rd(p_idx);
    case (p_op)
      4'd0: begin v = int'(m_a) + int'(r) + int'(m_c); m_c = v > 255; end
      4'd1: begin v = int'(m_a) - int'(r) - int'(m_c); m_c = v < 0; end
      4'd2: v = int'(m_a & r);
      4'd3: v = int'(m_a | r);
      4'd4: v = int'(m_a ^ r);
      4'd5: v = 255 - int'(m_a);
      4'd6, 4'd7: v = int'(r);
      4'd8: if (int'(p_idx) < NREGS) m_r[p_idx] = m_a;
      4'd9: if (int'(p_idx) < NREGS) m_r[p_idx] = p_imm;
      4'd10: m_c = 1'b0;
      4'd11: m_c = 1'b1;
      default: ;
    endcase
    if (p_op < 4'd8) begin
      m_a = 8'(v);
      m_z = m_a == 8'h00;
    end
  endtask

  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) m_r[i] = 8'h00;
      m_a = 0; m_c = 0; m_z = 0; busy = 0; e_done = 0;
      p_op = 0; p_idx = 0; p_imm = 0;
    end else begin
      e_done = 0;
      if (busy) begin
        apply();
        busy = 0;
        e_done = 1;
      end else if (cmd_valid) begin
        p_op = cmd_op; p_idx = cmd_idx; p_imm = cmd_imm;
        busy = 1;
      end
    end

  task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  always @(negedge clk)
    if (rst_n) begin
      chk("cmd_ready", 8'(cmd_ready), 8'(!busy));
      chk("done", 8'(done), 8'(e_done));
      chk("acc", acc, m_a);
      chk("carry", 8'(carry), 8'(m_c));
      chk("rd_data", rd_data, m_rd(rd_idx));
      chk("alu_a", alu_a, m_a);
      chk("alu_r", alu_r, m_rd(p_idx));
      chk("alu_op", 8'(alu_op), (busy && p_op < 4'd8) ? 8'(p_op) : 8'd6);
      chk("alu_ci", 8'(alu_ci), 8'(busy && p_op < 4'd2 && m_c));
`ifdef ALU_SEQ_ZFLAG_EN
      chk("zero", 8'(zero), 8'(m_z));
`endif
    end

  // called at a negedge; returns at the negedge after writeback
  task automatic issue(input logic [3:0] op, input logic [IDX_W-1:0] idx, input logic [7:0] imm);
    int t = 0;
    while (!cmd_ready && t < 8) begin @(negedge clk); t++; end
    if (!cmd_ready) begin
      n_vec++; n_bad++;
      $display("FAIL issue_timeout: cmd_ready got 0 expected 1");
    end
    cmd_valid = 1; cmd_op = op; cmd_idx = idx; cmd_imm = imm;
    @(negedge clk);
    cmd_valid = 0;
    @(negedge clk);
  endtask

  initial begin
    int dn;
    repeat (3) @(negedge clk);
    chk("rst_acc", acc, 8'h00);
    chk("rst_carry", 8'(carry), 8'h00);
    chk("rst_ready", 8'(cmd_ready), 8'h01);
    chk("rst_done", 8'(done), 8'h00);
    chk("rst_alu_op", 8'(alu_op), 8'h06);
    chk("rst_alu_r", alu_r, 8'h00);
    chk("rst_alu_ci", 8'(alu_ci), 8'h00);
    rst_n = 1;
    @(negedge clk);
    issue(4'd9, 2'd1, 8'h05);
    issue(4'd0, 2'd1, 8'h00);
    issue(4'd0, 2'd1, 8'h00);
    chk("adc_twice_acc", acc, 8'h0A);
    chk("adc_twice_c", 8'(carry), 8'h00);
    issue(4'd9, 2'd0, 8'hFF);
    issue(4'd6, 2'd0, 8'h00);
    issue(4'd11, 2'd0, 8'h00);
    issue(4'd0, 2'd0, 8'h00);
    chk("adc_ff_acc", acc, 8'hFF);
    chk("adc_ff_c", 8'(carry), 8'h01);
    issue(4'd2, 2'd0, 8'h00);
    chk("and_keeps_c", 8'(carry), 8'h01);
    issue(4'd9, 2'd3, 8'h10);
    issue(4'd6, 2'd3, 8'h00);
    issue(4'd10, 2'd0, 8'h00);
    issue(4'd9, 2'd2, 8'h20);
    issue(4'd1, 2'd2, 8'h00);
    chk("sbb1_acc", acc, 8'hF0);
    chk("sbb1_c", 8'(carry), 8'h01);
    issue(4'd1, 2'd2, 8'h00);
    chk("sbb2_acc", acc, 8'hCF);
    chk("sbb2_c", 8'(carry), 8'h00);
    dn = 0;
    cmd_valid = 1; cmd_op = 4'd0; cmd_idx = 2'd1;
    for (int i = 0; i < 8; i++) begin @(negedge clk); dn += int'(done); end
    cmd_valid = 0;
    chk("b2b_done_count", 8'(dn), 8'd4);
    chk("b2b_acc", acc, 8'hE3);
    issue(4'd3, 2'd0, 8'h00);
    chk("or_acc", acc, 8'hFF);
    issue(4'd5, 2'd0, 8'h00);
    chk("not_acc", acc, 8'h00);
    issue(4'd4, 2'd1, 8'h00);
    issue(4'd13, 2'd2, 8'hAA);
    chk("nop_acc", acc, 8'h05);
    issue(4'd7, 2'd3, 8'h00);
    chk("ld7_acc", acc, 8'h10);
    issue(4'd9, 2'd2, 8'h5A);
    issue(4'd6, 2'd2, 8'h00);
    issue(4'd8, 2'd3, 8'h00);
    rd_idx = 2'd3;
    #1 chk("st_rd_data", rd_data, 8'h5A);
`ifdef ALU_SEQ_ZFLAG_EN
    @(negedge clk);
    issue(4'd9, 2'd2, 8'h33);
    issue(4'd6, 2'd2, 8'h00);
    issue(4'd4, 2'd2, 8'h00);
    chk("xor_zero_acc", acc, 8'h00);
    chk("xor_zero_z", 8'(zero), 8'h01);
    issue(4'd10, 2'd0, 8'h00);
    chk("clc_keeps_z", 8'(zero), 8'h01);
`endif
    @(negedge clk);
    cmd_valid = 1; cmd_op = 4'd9; cmd_idx = 2'd1; cmd_imm = 8'h77;
    @(negedge clk);
    cmd_valid = 0;
    chk("exec_ready_low", 8'(cmd_ready), 8'h00);
    #2 rst_n = 0;
    #1;
    chk("abort_acc", acc, 8'h00);
    chk("abort_carry", 8'(carry), 8'h00);
    chk("abort_rd3", rd_data, 8'h00);
    chk("abort_done", 8'(done), 8'h00);
    @(negedge clk);
    chk("abort_done2", 8'(done), 8'h00);
    #1 rst_n = 1;
    rd_idx = 2'd1;
    @(negedge clk);
    chk("post_done", 8'(done), 8'h00);
    chk("post_r1", rd_data, 8'h00);
    chk("post_ready", 8'(cmd_ready), 8'h01);
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
